// File: rtl/earom_ctrl.sv
// rtl/earom_ctrl.sv - EAROM emulation: timed write/erase, registered reads, edge-detected strobe
// Optional host save/load port and dirty flag enabled by defining EAROM_HOST_PORT_EN.
module earom_ctrl #(
  parameter int DW = 8,
  parameter int AW = 6,
  parameter int WRITE_CYC = 16,
  parameter int ERASE_CYC = 16,
  parameter logic [DW-1:0] ERASED_VAL = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  input  logic          cs,
  input  logic          c1,
  input  logic          c2,
  input  logic          strobe,
  output logic          busy
`ifdef EAROM_HOST_PORT_EN
  ,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_din,
  input  logic          host_we,
  output logic [DW-1:0] host_dout,
  output logic          dirty,
  input  logic          dirty_clr
`endif
);

  localparam int MAXC = (WRITE_CYC > ERASE_CYC) ? WRITE_CYC : ERASE_CYC;
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] WLOAD = CW'(WRITE_CYC - 1);
  localparam logic [CW-1:0] ELOAD = CW'(ERASE_CYC - 1);

  typedef enum logic [1:0] {IDLE, WRITE, ERASE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] dout_q;
  logic          strobe_q;
  logic          accept;
  logic          rd_en;
  logic          commit;
  logic [DW-1:0] commit_data;
  logic [1:0]    mode;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  assign mode        = {c1, c2};
  assign accept      = strobe & ~strobe_q & cs & (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign dout        = dout_q;
  assign commit_data = (state_q == ERASE) ? ERASED_VAL : data_q;

  // Next-state: launch a command on an accepted edge, count down the busy window, commit at zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_en   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = addr;
          data_d = din;
          case (mode)
            2'b00: begin
              state_d = WRITE;
              cnt_d   = WLOAD;
            end
            2'b01: begin
              state_d = ERASE;
              cnt_d   = ELOAD;
            end
            2'b10:   rd_en = 1'b1;
            default: ;
          endcase
        end
      end
      WRITE, ERASE: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers, strobe history and registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      strobe_q <= strobe;
      if (rd_en) dout_q <= mem[addr];
    end
  end

  // Storage array, never reset; a CPU commit is written last so it wins an address collision
  always_ff @(posedge clk) begin
`ifdef EAROM_HOST_PORT_EN
    if (host_we) mem[host_addr] <= host_din;
`endif
    if (commit) mem[addr_q] <= commit_data;
  end

`ifdef EAROM_HOST_PORT_EN
  logic [DW-1:0] host_dout_q;
  logic          dirty_q;

  assign host_dout = host_dout_q;
  assign dirty     = dirty_q;

  // Host read-back every cycle; dirty set by a commit takes priority over a clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host_dout_q <= '0;
      dirty_q     <= 1'b0;
    end else begin
      host_dout_q <= mem[host_addr];
      if (commit) dirty_q <= 1'b1;
      else if (dirty_clr) dirty_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_earom_ctrl.sv
// tb/tb_earom_ctrl.sv - scoreboard bench for earom_ctrl (host-port checks under EAROM_HOST_PORT_EN)
module tb_earom_ctrl;

  localparam int W = 16;
  localparam logic [1:0] WR = 2'b00;
  localparam logic [1:0] ER = 2'b01;
  localparam logic [1:0] RD = 2'b10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] addr = '0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       cs = 1'b0;
  logic       c1 = 1'b1;
  logic       c2 = 1'b1;
  logic       strobe = 1'b0;
  logic       busy;
`ifdef EAROM_HOST_PORT_EN
  logic [5:0] host_addr = '0;
  logic [7:0] host_din = '0;
  logic       host_we = 1'b0;
  logic [7:0] host_dout;
  logic       dirty;
  logic       dirty_clr = 1'b0;
`endif

  earom_ctrl dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .din(din), .dout(dout),
    .cs(cs), .c1(c1), .c2(c2), .strobe(strobe), .busy(busy)
`ifdef EAROM_HOST_PORT_EN
    , .host_addr(host_addr), .host_din(host_din), .host_we(host_we),
    .host_dout(host_dout), .dirty(dirty), .dirty_clr(dirty_clr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
    int         at;
  } chk_t;

  chk_t sbq[$];
  int passed = 0;
  int total = 0;

  function automatic void push(input string n, input int sel, input logic [7:0] e, input int at);
    chk_t c;
    int i;
    c.name = n; c.sel = sel; c.exp = e; c.at = at;
    i = 0;
    while (i < sbq.size() && sbq[i].at <= at) i++;
    sbq.insert(i, c);
  endfunction

  always @(negedge clk) begin : monitor
    chk_t c;
    logic [7:0] act;
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      c = sbq.pop_front();
      case (c.sel)
        0: act = dout;
        1: act = {7'd0, busy};
`ifdef EAROM_HOST_PORT_EN
        2: act = host_dout;
        3: act = {7'd0, dirty};
`endif
        default: act = 'x;
      endcase
      total++;
      if (c.at != cyc)
        $display("FAIL %s: check for cycle %0d missed (now %0d)", c.name, c.at, cyc);
      else if (act !== c.exp)
        $display("FAIL %s: cycle %0d got %02h expected %02h", c.name, cyc, act, c.exp);
      else
        passed++;
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // acc: -1 no check, 0 ignored, 1 accepted full busy window, 2 accepted first busy cycle only
  task automatic cmd(input logic [1:0] m, input logic [5:0] a, input logic [7:0] d,
                     input int acc, input logic [7:0] e, input string n, output int t);
    @(negedge clk);
    addr = a; din = d; {c1, c2} = m; cs = 1'b1; strobe = 1'b1;
    t = cyc + 1;
    if (m == RD && acc >= 0) push(n, 0, e, t);
    if ((m == WR || m == ER) && acc >= 1) push({n, "_busy_on"}, 1, 8'd1, t);
    if ((m == WR || m == ER) && acc == 1) begin
      push({n, "_busy_last"}, 1, 8'd1, t + W - 1);
      push({n, "_busy_off"}, 1, 8'd0, t + W);
    end
    @(negedge clk);
    strobe = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    total++;
    $display("FAIL watchdog: run did not complete, %0d checks pending", sbq.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : stim
    int t, t0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    push("rst_dout", 0, 8'h00, cyc + 1);
    push("rst_busy", 1, 8'd0, cyc + 1);
`ifdef EAROM_HOST_PORT_EN
    push("rst_dirty", 3, 8'd0, cyc + 1);
`endif

    cmd(RD, 6'd5, 8'h00, -1, 8'h00, "rd5_init", t);
    push("rd_no_busy", 1, 8'd0, t);

    cmd(WR, 6'd3, 8'hA5, 1, 8'h00, "wr3", t);
    wait_cyc(t + W - 1);
    cmd(RD, 6'd3, 8'h00, 0, 8'hA5, "rd3_after_wr", t);

    cmd(WR, 6'd7, 8'h3C, 1, 8'h00, "wr7", t);
    wait_cyc(t + W - 1);
    cmd(RD, 6'd7, 8'h00, 0, 8'h3C, "rd7_after_wr", t);
    cmd(ER, 6'd7, 8'h00, 1, 8'h00, "er7", t);
    wait_cyc(t + W - 1);
    cmd(RD, 6'd7, 8'h00, 0, 8'h00, "rd7_after_er", t);

    cmd(RD, 6'd3, 8'h00, 0, 8'hA5, "rd3_prebusy", t);
    cmd(WR, 6'd10, 8'h66, 1, 8'h00, "wr10", t0);
    cmd(WR, 6'd3, 8'hFF, 0, 8'h00, "wr3_busy", t);
    cmd(RD, 6'd9, 8'h00, 0, 8'hA5, "rd9_busy_ignored", t);
    wait_cyc(t0 + W - 1);
    cmd(RD, 6'd3, 8'h00, 0, 8'hA5, "mem3_kept", t);
    cmd(RD, 6'd10, 8'h00, 0, 8'h66, "rd10", t);

    cmd(WR, 6'd12, 8'h42, 1, 8'h00, "wr12", t);
    wait_cyc(t + W - 1);
    @(negedge clk);
    addr = 6'd12; {c1, c2} = RD; cs = 1'b1; strobe = 1'b1;
    push("rd12", 0, 8'h42, cyc + 1);
    @(negedge clk);
    addr = 6'd10;
    push("held_no_retrigger", 0, 8'h42, cyc + 4);
    repeat (5) @(negedge clk);
    strobe = 1'b0;
    @(negedge clk);
    cs = 1'b0; addr = 6'd10; strobe = 1'b1;
    push("cs_low_ignored", 0, 8'h42, cyc + 1);
    @(negedge clk);
    strobe = 1'b0; cs = 1'b1;

    cmd(WR, 6'd2, 8'h22, 1, 8'h00, "wr2", t);
    wait_cyc(t + W - 1);
    cmd(WR, 6'd2, 8'h11, 2, 8'h00, "wr2_abort", t);
    push("busy_mid", 1, 8'd1, t + 6);
    wait_cyc(t + 6);
    @(posedge clk);
    #1 reset_n = 1'b0;
    push("abort_busy", 1, 8'd0, t + 7);
    push("abort_dout", 0, 8'h00, t + 7);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cmd(RD, 6'd2, 8'h00, 0, 8'h22, "abort_kept_old", t);

`ifdef EAROM_HOST_PORT_EN
    @(negedge clk);
    host_addr = 6'd4; host_din = 8'h77; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    push("host_dout4", 2, 8'h77, cyc + 1);
    cmd(RD, 6'd4, 8'h00, 0, 8'h77, "cpu_rd_host4", t);
    push("dirty_idle", 3, 8'd0, t);

    cmd(WR, 6'd20, 8'h55, 1, 8'h00, "wr20", t);
    wait_cyc(t + W - 1);
    host_addr = 6'd20; host_din = 8'h99; host_we = 1'b1; dirty_clr = 1'b1;
    push("dirty_set_wins", 3, 8'd1, t + W);
    push("dirty_clr_alone", 3, 8'd0, t + W + 1);
    @(negedge clk);
    host_we = 1'b0;
    @(negedge clk);
    dirty_clr = 1'b0;
    cmd(RD, 6'd20, 8'h00, 0, 8'h55, "collision_commit_wins", t);
`endif

    wait_cyc(cyc + 4);
    if (sbq.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
